// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: load-use stall, jump/trap redirect,
// multi-cycle mul/div issue with bounded wait and timeout trap.
module pipe_ctrl #(
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0004,
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic [1:0]  id_rs_used_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic        id_is_load_i,
    input  logic        id_is_md_i,
    input  logic        id_err_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        md_done_i,
    output logic        stall_o,
    output logic        bubble_o,
    output logic        hold_ex_o,
    output logic        flush_o,
    output logic        pc_set_o,
    output logic [31:0] pc_addr_o,
    output logic        md_start_o,
    output logic        exc_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] MD_LAST_C = 8'(MD_TIMEOUT - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        ld_pend_r;
    logic [4:0]  ld_rd_r;
    logic [7:0]  md_cnt_r;
    logic [31:0] stall_cnt_r;
    logic        rs1_hit_s;
    logic        rs2_hit_s;
    logic        hazard_s;

    assign rs1_hit_s = id_rs_used_i[0] & (id_rs1_addr_i == ld_rd_r);
    assign rs2_hit_s = id_rs_used_i[1] & (id_rs2_addr_i == ld_rd_r);
    assign hazard_s  = (state_r == RUN) & id_valid_i & ld_pend_r & (rs1_hit_s | rs2_hit_s);
    assign stall_cnt_o = stall_cnt_r;

    // Control outputs and next state; everything is held low while in reset.
    always_comb begin
        stall_o     = 1'b0;
        bubble_o    = 1'b0;
        hold_ex_o   = 1'b0;
        flush_o     = 1'b0;
        pc_set_o    = 1'b0;
        pc_addr_o   = 32'h0000_0000;
        md_start_o  = 1'b0;
        exc_o       = 1'b0;
        state_nxt_s = state_r;
        if (!rst_n) begin
            state_nxt_s = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (ex_jump_i) begin
                        pc_set_o  = 1'b1;
                        pc_addr_o = ex_jump_addr_i;
                        flush_o   = 1'b1;
                    end else if (id_valid_i && id_err_i) begin
                        pc_set_o  = 1'b1;
                        pc_addr_o = TRAP_VEC;
                        flush_o   = 1'b1;
                        exc_o     = 1'b1;
                    end else if (hazard_s) begin
                        stall_o  = 1'b1;
                        bubble_o = 1'b1;
                    end else if (id_valid_i && id_is_md_i) begin
                        md_start_o  = 1'b1;
                        state_nxt_s = MD_WAIT;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                MD_WAIT: begin
                    // A result arriving on the timeout cycle takes precedence.
                    if (md_done_i) begin
                        state_nxt_s = RUN;
                    end else if (md_cnt_r == MD_LAST_C) begin
                        exc_o       = 1'b1;
                        flush_o     = 1'b1;
                        pc_set_o    = 1'b1;
                        pc_addr_o   = TRAP_VEC;
                        state_nxt_s = RUN;
                    end else begin
                        stall_o   = 1'b1;
                        hold_ex_o = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                end
            endcase
        end
    end

    // State, load-pending tracker, mul/div wait counter and stall statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= RUN;
            ld_pend_r   <= 1'b0;
            ld_rd_r     <= 5'd0;
            md_cnt_r    <= 8'd0;
            stall_cnt_r <= 32'h0000_0000;
        end else begin
            state_r   <= state_nxt_s;
            ld_pend_r <= id_valid_i & id_is_load_i & (id_rd_addr_i != 5'd0) & ~stall_o & ~flush_o;
            ld_rd_r   <= id_rd_addr_i;
            if (state_r == RUN) begin
                md_cnt_r <= 8'd0;
            end else begin
                md_cnt_r <= md_cnt_r + 8'd1;
            end
            if (stall_o && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, multi-cycle
// mul/div sequences, and randomized traffic against a reference model.
module tb_pipe_ctrl;

    localparam logic [31:0] TRAP = 32'h0000_0004;
    localparam int          TMO  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic [1:0]  id_rs_used_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_is_load_i;
    logic        id_is_md_i;
    logic        id_err_i;
    logic        ex_jump_i;
    logic [31:0] ex_jump_addr_i;
    logic        md_done_i;
    logic        stall_o;
    logic        bubble_o;
    logic        hold_ex_o;
    logic        flush_o;
    logic        pc_set_o;
    logic [31:0] pc_addr_o;
    logic        md_start_o;
    logic        exc_o;
    logic [31:0] stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.TRAP_VEC(TRAP), .MD_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs_used_i(id_rs_used_i), .id_rd_addr_i(id_rd_addr_i),
        .id_is_load_i(id_is_load_i), .id_is_md_i(id_is_md_i),
        .id_err_i(id_err_i), .ex_jump_i(ex_jump_i),
        .ex_jump_addr_i(ex_jump_addr_i), .md_done_i(md_done_i),
        .stall_o(stall_o), .bubble_o(bubble_o), .hold_ex_o(hold_ex_o),
        .flush_o(flush_o), .pc_set_o(pc_set_o), .pc_addr_o(pc_addr_o),
        .md_start_o(md_start_o), .exc_o(exc_o), .stall_cnt_o(stall_cnt_o)
    );

    typedef struct {
        logic        rst_n, valid;
        logic [4:0]  rs1, rs2;
        logic [1:0]  used;
        logic [4:0]  rd;
        logic        ld, md, err, jmp;
        logic [31:0] jaddr;
        logic        done;
    } in_t;

    typedef struct {
        logic        stall, bubble, hold, flush, pcset;
        logic [31:0] pcaddr;
        logic        mds, exc;
        logic [31:0] scnt;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    function automatic in_t mkin(logic r, logic v, logic [4:0] s1, logic [4:0] s2,
                                 logic [1:0] u, logic [4:0] d, logic l, logic m,
                                 logic e, logic j, logic [31:0] ja, logic dn);
        in_t x;
        x.rst_n = r; x.valid = v; x.rs1 = s1; x.rs2 = s2; x.used = u; x.rd = d;
        x.ld = l; x.md = m; x.err = e; x.jmp = j; x.jaddr = ja; x.done = dn;
        return x;
    endfunction

    function automatic out_t mkout(logic st, logic bu, logic ho, logic fl, logic ps,
                                   logic [31:0] pa, logic ms, logic ex, logic [31:0] sc);
        out_t o;
        o.stall = st; o.bubble = bu; o.hold = ho; o.flush = fl; o.pcset = ps;
        o.pcaddr = pa; o.mds = ms; o.exc = ex; o.scnt = sc;
        return o;
    endfunction

    function automatic logic [70:0] pk(out_t o);
        return {o.stall, o.bubble, o.hold, o.flush, o.pcset, o.mds, o.exc, o.pcaddr, o.scnt};
    endfunction

    // Drive one cycle of inputs, check mid-cycle, then advance past the edge.
    task automatic run(input in_t v, input out_t e, input string name);
        logic [70:0] act;
        rst_n = v.rst_n; id_valid_i = v.valid; id_rs1_addr_i = v.rs1;
        id_rs2_addr_i = v.rs2; id_rs_used_i = v.used; id_rd_addr_i = v.rd;
        id_is_load_i = v.ld; id_is_md_i = v.md; id_err_i = v.err;
        ex_jump_i = v.jmp; ex_jump_addr_i = v.jaddr; md_done_i = v.done;
        #4;
        act = {stall_o, bubble_o, hold_ex_o, flush_o, pc_set_o, md_start_o, exc_o,
               pc_addr_o, stall_cnt_o};
        n_tests++;
        if (act !== pk(e)) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (stall,bub,hold,flush,pcset,mds,exc,pc,cnt)",
                     name, act, pk(e));
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model state: in mul/div wait, cycles waited, pending load, stall count.
    bit          m_md;
    int          m_wait;
    bit          m_ld;
    int          m_ld_rd;
    longint      m_scnt;

    function automatic out_t model_eval(in_t i);
        out_t o = mkout(0, 0, 0, 0, 0, 32'h0, 0, 0, m_scnt[31:0]);
        bit hit;
        if (!i.rst_n) return o;
        hit = m_ld && ((i.used[0] && int'(i.rs1) == m_ld_rd) ||
                       (i.used[1] && int'(i.rs2) == m_ld_rd));
        if (!m_md) begin
            if (i.jmp) begin
                o.pcset = 1; o.flush = 1; o.pcaddr = i.jaddr;
            end else if (i.valid && i.err) begin
                o.pcset = 1; o.flush = 1; o.exc = 1; o.pcaddr = TRAP;
            end else if (i.valid && hit) begin
                o.stall = 1; o.bubble = 1;
            end else if (i.valid && i.md) begin
                o.mds = 1;
            end
        end else begin
            if (i.done) begin
                o.stall = 0;
            end else if (m_wait == TMO - 1) begin
                o.exc = 1; o.flush = 1; o.pcset = 1; o.pcaddr = TRAP;
            end else begin
                o.stall = 1; o.hold = 1;
            end
        end
        return o;
    endfunction

    task automatic model_step(in_t i, out_t o);
        if (!i.rst_n) begin
            m_md = 0; m_wait = 0; m_ld = 0; m_ld_rd = 0; m_scnt = 0;
        end else begin
            if (o.stall && m_scnt < 64'hFFFF_FFFF) m_scnt++;
            m_ld    = i.valid && i.ld && (i.rd != 0) && !o.stall && !o.flush;
            m_ld_rd = int'(i.rd);
            if (!m_md) begin
                if (o.mds) begin m_md = 1; m_wait = 0; end
            end else if (i.done || o.exc) begin
                m_md = 0;
            end else begin
                m_wait++;
            end
        end
    endtask

    vec_t tbl[23];
    in_t  idle;
    in_t  waitv;
    in_t  issue;
    in_t  rv;
    out_t re;

    initial begin
        idle  = mkin(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h0, 0);
        waitv = mkin(1, 1, 5, 5, 2'b11, 5, 1, 1, 1, 1, 32'h300, 0);
        issue = mkin(1, 1, 1, 2, 2'b11, 3, 0, 1, 0, 0, 32'h0, 0);

        //              rst v  rs1 rs2 used  rd ld md er jp jaddr        dn
        tbl[0]  = '{mkin(0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h55, 0),  mkout(0,0,0,0,0,32'h0,0,0,0)};
        tbl[1]  = '{mkin(1, 1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,0)};
        tbl[2]  = '{mkin(1, 1, 5, 1, 2'b01, 6, 0, 0, 0, 0, 32'h0, 0),   mkout(1,1,0,0,0,32'h0,0,0,0)};
        tbl[3]  = '{mkin(1, 1, 5, 1, 2'b01, 6, 0, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,1)};
        tbl[4]  = '{mkin(1, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,1)};
        tbl[5]  = '{mkin(1, 1, 0, 1, 2'b01, 7, 0, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,1)};
        tbl[6]  = '{mkin(1, 1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,1)};
        tbl[7]  = '{mkin(1, 1, 3, 5, 2'b10, 7, 0, 0, 0, 0, 32'h0, 0),   mkout(1,1,0,0,0,32'h0,0,0,1)};
        tbl[8]  = '{mkin(1, 1, 0, 0, 2'b00, 0, 0, 1, 1, 1, 32'h100, 0), mkout(0,0,0,1,1,32'h100,0,0,2)};
        tbl[9]  = '{mkin(1, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h0, 0),   mkout(0,0,0,1,1,TRAP,0,1,2)};
        tbl[10] = '{mkin(1, 0, 0, 0, 2'b00, 0, 1, 1, 1, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,2)};
        tbl[11] = '{mkin(1, 1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,2)};
        tbl[12] = '{mkin(1, 0, 9, 0, 2'b01, 1, 0, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,2)};
        tbl[13] = '{mkin(1, 1, 9, 0, 2'b01, 1, 0, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,2)};
        tbl[14] = '{mkin(1, 1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,2)};
        tbl[15] = '{mkin(1, 1, 5, 0, 2'b01, 6, 0, 0, 0, 1, 32'h200, 0), mkout(0,0,0,1,1,32'h200,0,0,2)};
        tbl[16] = '{mkin(1, 1, 0, 0, 2'b00, 5, 1, 0, 1, 0, 32'h0, 0),   mkout(0,0,0,1,1,TRAP,0,1,2)};
        tbl[17] = '{mkin(1, 1, 5, 0, 2'b01, 6, 0, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,2)};
        tbl[18] = '{mkin(1, 1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,2)};
        tbl[19] = '{mkin(1, 1, 4, 0, 2'b01, 8, 0, 1, 0, 0, 32'h0, 0),   mkout(1,1,0,0,0,32'h0,0,0,2)};
        tbl[20] = '{mkin(1, 1, 4, 0, 2'b01, 8, 0, 1, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,1,0,3)};
        tbl[21] = '{mkin(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,3)};
        tbl[22] = '{mkin(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h0, 0),   mkout(0,0,0,0,0,32'h0,0,0,0)};

        // Bring registers to a known state before the first checked cycle.
        for (int i = 0; i < 2; i++) begin
            rst_n = 1'b0; id_valid_i = 1'b0; id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
            id_rs_used_i = 2'b00; id_rd_addr_i = 5'd0; id_is_load_i = 1'b0;
            id_is_md_i = 1'b0; id_err_i = 1'b0; ex_jump_i = 1'b0;
            ex_jump_addr_i = 32'h0; md_done_i = 1'b0;
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 23; i++) begin
            run(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // mul/div completing after five wait cycles
        run(issue, mkout(0,0,0,0,0,32'h0,1,0,0), "md5_issue");
        for (int k = 0; k < 5; k++)
            run(waitv, mkout(1,0,1,0,0,32'h0,0,0,32'(k)), "md5_wait");
        run(mkin(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h300, 1), mkout(0,0,0,0,0,32'h0,0,0,5), "md5_done");
        run(idle, mkout(0,0,0,0,0,32'h0,0,0,5), "md5_after");

        // mul/div never completing: trap on the last allowed wait cycle
        run(issue, mkout(0,0,0,0,0,32'h0,1,0,5), "tmo_issue");
        for (int k = 0; k < TMO - 1; k++)
            run(waitv, mkout(1,0,1,0,0,32'h0,0,0,32'(5 + k)), "tmo_wait");
        run(waitv, mkout(0,0,0,1,1,TRAP,0,1,68), "tmo_trap");
        run(idle, mkout(0,0,0,0,0,32'h0,0,0,68), "tmo_run");

        // completion on the timeout cycle wins over the trap
        run(issue, mkout(0,0,0,0,0,32'h0,1,0,68), "race_issue");
        for (int k = 0; k < TMO - 1; k++)
            run(waitv, mkout(1,0,1,0,0,32'h0,0,0,32'(68 + k)), "race_wait");
        run(mkin(1, 1, 5, 5, 2'b11, 5, 1, 1, 1, 1, 32'h300, 1), mkout(0,0,0,0,0,32'h0,0,0,131), "race_done");
        run(idle, mkout(0,0,0,0,0,32'h0,0,0,131), "race_after");

        // randomized traffic against the reference model
        run(mkin(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h0, 0), mkout(0,0,0,0,0,32'h0,0,0,131), "rand_rst");
        m_md = 0; m_wait = 0; m_ld = 0; m_ld_rd = 0; m_scnt = 0;
        for (int n = 0; n < 3000; n++) begin
            rv = mkin(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom),
                      5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                      ($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 5) == 0));
            re = model_eval(rv);
            run(rv, re, "rand");
            model_step(rv, re);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
